digit_entry: RTL

Upstream input stage for the combination lock. Takes the four raw digit switches and turns them into four clean BCD digits in the system clock domain. Each switch is synchronised and debounced, and its rising edge becomes a one-cycle press that increments a mod-10 digit. The lock controller consumes `q0..q3` directly, and no switch is ever used as a clock.

---
 rtl/lock_pkg.sv | 50 +++++
 rtl/key_debounce.sv | 73 +++++++
 rtl/digit_entry.sv | 103 ++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// -----------------------------------------------------------------------------
// lock_pkg
// Shared definitions for the combination lock datapath.
//   NUM_KEYS  : number of digit switches / BCD digits
//   BCD_W     : width of one BCD digit
//   DIGIT_MAX : largest legal BCD digit value (wraps back to 0 after this)
//   bcd_t     : one BCD digit
//   key_vec_t : one bit per key (press vectors)
//   key_idx_t : index of one key
// Helper functions:
//   bcd_inc    : mod-10 increment of a BCD digit
//   lowest_set : index of the lowest set bit of a key vector (0 if none)
// -----------------------------------------------------------------------------
package lock_pkg;

  localparam int NUM_KEYS = 4;
  localparam int BCD_W    = 4;
  localparam int IDX_W    = $clog2(NUM_KEYS);

  typedef logic [BCD_W-1:0]    bcd_t;
  typedef logic [NUM_KEYS-1:0] key_vec_t;
  typedef logic [IDX_W-1:0]    key_idx_t;

  localparam bcd_t DIGIT_MAX = 4'd9;

  // Mod-10 increment: 9 wraps to 0 so a digit can never leave 0..9.
  function automatic bcd_t bcd_inc(input bcd_t value);
    bcd_t result;
    if (value == DIGIT_MAX) begin
      result = '0;
    end else begin
      result = value + bcd_t'(1);
    end
    return result;
  endfunction

  // Priority encoder favouring the lowest index. Scanning from the top down
  // lets the lowest set bit overwrite any higher one found earlier.
  function automatic key_idx_t lowest_set(input key_vec_t vec);
    key_idx_t idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = key_idx_t'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One raw switch in, one single-cycle press pulse out, all in the clk domain.
// The raw level goes through a two-flop synchroniser, then a debounce filter
// that only accepts a new level after it has differed from the accepted level
// for DB_CYCLES consecutive cycles, then a rising-edge detector.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high; clears synchroniser, counter and levels
//   raw   : asynchronous raw switch level
//   press : one-cycle pulse on the accepted rising edge (combinational from
//           flops only, never from raw)
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  // Counter must be able to hold DB_CYCLES-1; sized from DB_CYCLES+1 so that
  // DB_CYCLES = 1 still yields a one-bit counter.
  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             lvl_q;
  logic             lvl_d;
  logic             lvlPrev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Debounce filter: any cycle where the synchronised level agrees with the
  // accepted level restarts the count, so a glitch shorter than DB_CYCLES
  // never gets through. The counter only climbs while the levels disagree
  // and the new level is adopted on the DB_CYCLES-th disagreeing cycle.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser, filter state and the delayed copy of the accepted level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      lvl_q     <= 1'b0;
      lvlPrev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      lvl_q     <= lvl_d;
      lvlPrev_q <= lvl_q;
      cnt_q     <= cnt_d;
    end
  end

  // Rising edge of the accepted level only; releases are deliberately ignored.
  assign press = lvl_q & ~lvlPrev_q;

endmodule

// File: rtl/digit_entry.sv
// -----------------------------------------------------------------------------
// digit_entry
// Input stage for the combination lock. Each of the four raw switches is
// cleaned up by its own key_debounce instance; every accepted press bumps the
// matching BCD digit (mod 10) while entry is enabled.
// Ports:
//   clk       : system clock
//   reset     : synchronous, active-high; clears everything
//   btn_raw   : asynchronous raw switch levels, bit i drives digit i
//   enable    : increments permitted
//   clear     : synchronous clear of all digits to 0 (drops same-cycle presses)
//   q0..q3    : BCD digits 0..9
//   key_stb   : one-cycle pulse whenever at least one digit incremented
//   key_idx   : lowest digit index incremented at the most recent key_stb
// -----------------------------------------------------------------------------
module digit_entry
  import lock_pkg::*;
#(
  parameter int DB_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] btn_raw,
  input  logic                enable,
  input  logic                clear,
  output logic [BCD_W-1:0]    q0,
  output logic [BCD_W-1:0]    q1,
  output logic [BCD_W-1:0]    q2,
  output logic [BCD_W-1:0]    q3,
  output logic                key_stb,
  output logic [IDX_W-1:0]    key_idx
);

  key_vec_t press;

  bcd_t     digit_q [NUM_KEYS];
  bcd_t     digit_d [NUM_KEYS];
  logic     keyStb_q;
  logic     keyStb_d;
  key_idx_t keyIdx_q;
  key_idx_t keyIdx_d;

  // One independent synchroniser/debounce/edge-detect chain per switch.
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_key_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[g]),
      .press(press[g])
    );
  end

  // Digit next-state: clear beats a press in the same cycle, and a press that
  // arrives while entry is disabled is simply lost rather than remembered.
  // Several digits may step in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      digit_d[i] = digit_q[i];
      if (clear) begin
        digit_d[i] = '0;
      end else if (enable && press[i]) begin
        digit_d[i] = bcd_inc(digit_q[i]);
      end
    end
  end

  // Strobe fires once for any set of simultaneous accepted presses; the index
  // only moves when the strobe does, so the controller can read it afterwards.
  always_comb begin
    keyStb_d = ~clear & enable & (|press);
    keyIdx_d = keyIdx_q;
    if (keyStb_d) begin
      keyIdx_d = lowest_set(press);
    end
  end

  // Output registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        digit_q[i] <= '0;
      end
      keyStb_q <= 1'b0;
      keyIdx_q <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        digit_q[i] <= digit_d[i];
      end
      keyStb_q <= keyStb_d;
      keyIdx_q <= keyIdx_d;
    end
  end

  assign q0      = digit_q[0];
  assign q1      = digit_q[1];
  assign q2      = digit_q[2];
  assign q3      = digit_q[3];
  assign key_stb = keyStb_q;
  assign key_idx = keyIdx_q;

endmodule
